// File: rtl/btn_conditioner.sv
// Per-channel button conditioner: 2-flop synchronizer, counter debounce,
// registered press/release pulses and a press-and-hold auto-repeat step.
module btn_conditioner #(
    parameter int N_BTN         = 2,
    parameter int DEBOUNCE_CYC  = 1_000_000,
    parameter int REPEAT_DELAY  = 50_000_000,
    parameter int REPEAT_PERIOD = 10_000_000
) (
    input  logic             clk_i,
    input  logic             arstn_i,
    input  logic [N_BTN-1:0] btn_i,
    output logic [N_BTN-1:0] level_o,
    output logic [N_BTN-1:0] press_o,
    output logic [N_BTN-1:0] release_o,
    output logic [N_BTN-1:0] step_o
);

    localparam int CNT_W   = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam int TMR_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [TMR_W-1:0] RD_LAST  = TMR_W'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
    localparam logic [TMR_W-1:0] RP_LAST  = TMR_W'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } state_e;

    for (genvar g = 0; g < N_BTN; g++) begin : g_chan
        logic [1:0]       sync_q, sync_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic [TMR_W-1:0] tmr_q, tmr_d;
        logic             level_q, level_d;
        logic             press_q, press_d;
        logic             release_q, release_d;
        logic             step_q, step_d;
        logic             rise, fall, tick;
        logic             btn_s;
        state_e           state_q, state_d;

        assign btn_s = sync_q[1];

        always_ff @(posedge clk_i or negedge arstn_i) begin
            if (!arstn_i) begin
                sync_q    <= '0;
                cnt_q     <= '0;
                tmr_q     <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                step_q    <= 1'b0;
                state_q   <= IDLE;
            end else begin
                sync_q    <= sync_d;
                cnt_q     <= cnt_d;
                tmr_q     <= tmr_d;
                level_q   <= level_d;
                press_q   <= press_d;
                release_q <= release_d;
                step_q    <= step_d;
                state_q   <= state_d;
            end
        end

        // Any cycle where the synchronized input agrees with the level restarts the count.
        always_comb begin
            sync_d  = {sync_q[0], btn_i[g]};
            cnt_d   = '0;
            level_d = level_q;
            rise    = 1'b0;
            fall    = 1'b0;
            if (btn_s != level_q) begin
                if (cnt_q == CNT_LAST) begin
                    level_d = ~level_q;
                    rise    = ~level_q;
                    fall    = level_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end

        always_comb begin
            state_d = state_q;
            tmr_d   = tmr_q;
            tick    = 1'b0;
            case (state_q)
                IDLE: begin
                    tmr_d = '0;
                    if (rise) state_d = HOLD;
                end
                HOLD: begin
                    if (REPEAT_DELAY == 0) begin
                        tmr_d = '0;
                    end else if (tmr_q == RD_LAST) begin
                        tick    = 1'b1;
                        state_d = REPEAT;
                        tmr_d   = '0;
                    end else begin
                        tmr_d = tmr_q + 1'b1;
                    end
                end
                REPEAT: begin
                    if (tmr_q == RP_LAST) begin
                        tick  = 1'b1;
                        tmr_d = '0;
                    end else begin
                        tmr_d = tmr_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    tmr_d   = '0;
                end
            endcase
            // Release wins over a repeat step that falls due in the same cycle.
            if (fall) begin
                state_d = IDLE;
                tmr_d   = '0;
            end
        end

        always_comb begin
            press_d   = rise;
            release_d = fall;
            step_d    = rise | (tick & ~fall);
        end

        assign level_o[g]   = level_q;
        assign press_o[g]   = press_q;
        assign release_o[g] = release_q;
        assign step_o[g]    = step_q;
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed, table-driven bench for btn_conditioner with short debounce and
// repeat timings; plus a hand-written asynchronous reset sequence.
module tb_btn_conditioner;

    localparam int N_BTN = 2;

    typedef struct {
        logic [1:0] btn;
        logic [1:0] level;
        logic [1:0] press;
        logic [1:0] rel;
        logic [1:0] step;
    } vec_t;

    logic       clk_i   = 1'b0;
    logic       arstn_i = 1'b0;
    logic [1:0] btn_i   = 2'b00;
    logic [1:0] level_o, press_o, release_o, step_o;

    int   checks   = 0;
    int   failures = 0;
    vec_t vecs[$];

    btn_conditioner #(
        .N_BTN        (N_BTN),
        .DEBOUNCE_CYC (4),
        .REPEAT_DELAY (10),
        .REPEAT_PERIOD(3)
    ) dut (
        .clk_i    (clk_i),
        .arstn_i  (arstn_i),
        .btn_i    (btn_i),
        .level_o  (level_o),
        .press_o  (press_o),
        .release_o(release_o),
        .step_o   (step_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string name, input logic [1:0] actual, input logic [1:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%b expected=%b", name, actual, expected);
        end
    endtask

    task automatic checkAll(input string tag, input vec_t v);
        checkOutput({tag, ".level"},   level_o,   v.level);
        checkOutput({tag, ".press"},   press_o,   v.press);
        checkOutput({tag, ".release"}, release_o, v.rel);
        checkOutput({tag, ".step"},    step_o,    v.step);
    endtask

    task automatic applyStimulus(input string tag, input vec_t v);
        btn_i = v.btn;
        @(posedge clk_i);
        #1;
        checkAll(tag, v);
    endtask

    function automatic void addVec(input logic [1:0] btn, input logic [1:0] level,
                                   input logic [1:0] press, input logic [1:0] rel,
                                   input logic [1:0] step);
        vec_t v;
        v.btn   = btn;
        v.level = level;
        v.press = press;
        v.rel   = rel;
        v.step  = step;
        vecs.push_back(v);
    endfunction

    function automatic logic isStep0(input int e);
        int steps[10] = '{6, 16, 19, 22, 25, 28, 31, 34, 37, 40};
        foreach (steps[i]) if (steps[i] == e) return 1'b1;
        return 1'b0;
    endfunction

    initial begin
        vec_t zero;
        vec_t v;

        // Quiet lead-in after reset.
        for (int e = 1; e <= 3; e++) addVec(2'b00, 2'b00, 2'b00, 2'b00, 2'b00);

        // Channel 0: press seen on edge 6, held into repeat, btn drops before
        // edge 38 so the release lands on edge 43 where a step would be due.
        for (int e = 1; e <= 50; e++)
            addVec((e <= 37) ? 2'b01 : 2'b00,
                   (e >= 6 && e <= 42) ? 2'b01 : 2'b00,
                   (e == 6) ? 2'b01 : 2'b00,
                   (e == 43) ? 2'b01 : 2'b00,
                   isStep0(e) ? 2'b01 : 2'b00);

        // Channel 0: a pulse exactly DEBOUNCE_CYC long is accepted both ways.
        for (int e = 1; e <= 14; e++)
            addVec((e <= 4) ? 2'b01 : 2'b00,
                   (e >= 6 && e <= 9) ? 2'b01 : 2'b00,
                   (e == 6) ? 2'b01 : 2'b00,
                   (e == 10) ? 2'b01 : 2'b00,
                   (e == 6) ? 2'b01 : 2'b00);

        // Channel 1: 3-cycle bounce segments never qualify.
        for (int i = 0; i < 46; i++)
            addVec((i < 40 && ((i / 3) % 2 == 0)) ? 2'b10 : 2'b00,
                   2'b00, 2'b00, 2'b00, 2'b00);

        // Both channels pressed together, held into repeat.
        for (int e = 1; e <= 20; e++)
            addVec(2'b11,
                   (e >= 6) ? 2'b11 : 2'b00,
                   (e == 6) ? 2'b11 : 2'b00,
                   2'b00,
                   (e == 6 || e == 16 || e == 19) ? 2'b11 : 2'b00);

        zero.btn = 2'b00; zero.level = 2'b00; zero.press = 2'b00; zero.rel = 2'b00; zero.step = 2'b00;

        #1;
        checkAll("reset", zero);
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        arstn_i = 1'b1;

        foreach (vecs[i]) applyStimulus($sformatf("vec%0d", i), vecs[i]);

        // Reset mid-repeat with both buttons still held.
        #2;
        arstn_i = 1'b0;
        #1;
        checkAll("rst_now", zero);
        repeat (2) @(posedge clk_i);
        #1;
        checkAll("rst_hold", zero);
        @(negedge clk_i);
        arstn_i = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            v.btn   = 2'b11;
            v.level = (e >= 6) ? 2'b11 : 2'b00;
            v.press = (e == 6) ? 2'b11 : 2'b00;
            v.rel   = 2'b00;
            v.step  = (e == 6) ? 2'b11 : 2'b00;
            applyStimulus($sformatf("post_rst%0d", e), v);
        end

        $display("[TB] directed sequences complete");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout actual=running expected=finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule

// File: doc/btn_conditioner.md
BTN_CONDITIONER -- requirements
Module: btn_conditioner

Interface
REQ-001 SHALL have parameter N_BTN, default 2, number of independent button channels (bit 0 = BTNL, bit 1 = BTNR).
REQ-002 SHALL have parameter DEBOUNCE_CYC, default 1_000_000, number of consecutive stable cycles required to accept a level change (legal range >=1).
REQ-003 SHALL have parameter REPEAT_DELAY, default 50_000_000, cycles from press to first auto-repeat step (0 disables auto-repeat).
REQ-004 SHALL have parameter REPEAT_PERIOD, default 10_000_000, cycles between subsequent auto-repeat steps (legal range >=1).
REQ-005 SHALL have port clk_i, input, 1, clock clk_i.
REQ-006 SHALL have port arstn_i, input, 1, reset arstn_i, asynchronous, active-low.
REQ-007 SHALL have port btn_i, input, N_BTN, raw asynchronous button levels, 1 = pressed.
REQ-008 SHALL have port level_o, output, N_BTN, debounced button level.
REQ-009 SHALL have port press_o, output, N_BTN, one-cycle pulse on accepted 0->1 transition.
REQ-010 SHALL have port release_o, output, N_BTN, one-cycle pulse on accepted 1->0 transition.
REQ-011 SHALL have port step_o, output, N_BTN, one-cycle pulse on press and on each auto-repeat.

Function
REQ-012 SHALL process each channel independently; no shared state between channels.
REQ-013 SHALL pass each btn_i bit through a 2-flop synchronizer; only the second flop output (btn_s) is used downstream.
REQ-014 SHALL keep a per-channel stability counter: cleared in any cycle btn_s == level_o; incremented when btn_s != level_o.
REQ-015 SHALL invert level_o and clear the counter on the edge where btn_s != level_o and the counter equals DEBOUNCE_CYC-1.
REQ-016 SHALL therefore change level_o on the (DEBOUNCE_CYC+2)th rising edge after btn_i becomes stable; any mismatch shorter than DEBOUNCE_CYC cycles produces no output change.
REQ-017 SHALL assert press_o (release_o) for exactly one cycle, registered, in the first cycle level_o reads 1 (0).
REQ-018 SHALL implement per-channel FSM states IDLE, HOLD, REPEAT with a repeat timer sized for max(REPEAT_DELAY, REPEAT_PERIOD).
REQ-019 IDLE: on press -> HOLD, timer cleared, step_o asserted in the press_o cycle.
REQ-020 HOLD: timer increments each cycle; when timer reaches REPEAT_DELAY-1 -> step_o pulse next cycle, state REPEAT, timer cleared; if REPEAT_DELAY==0, remain in HOLD and never repeat.
REQ-021 REPEAT: step_o pulse every REPEAT_PERIOD cycles; timer wraps to 0 after each pulse.
REQ-022 SHALL, from press cycle P, produce step_o at P, P+REPEAT_DELAY, P+REPEAT_DELAY+k*REPEAT_PERIOD (k>=1) while level_o stays 1.
REQ-023 SHALL, on release (level_o falling) from HOLD or REPEAT, go to IDLE and clear the timer; a step due in the release cycle is suppressed.
REQ-024 SHALL allow press_o/release_o/step_o of different channels in the same cycle.
REQ-025 SHALL never assert press_o and release_o of one channel in the same cycle.

Reset
REQ-026 SHALL, while arstn_i is 0, asynchronously force synchronizer flops, counters, timers, level_o, press_o, release_o, step_o to 0 and every FSM to IDLE.
REQ-027 SHALL, for a button held through reset deassertion, report press DEBOUNCE_CYC+2 edges after deassertion (level starts at 0).
REQ-028 SHALL, on reset mid-hold or mid-repeat, drop all pulses immediately and emit no release_o.

Verification (DEBOUNCE_CYC=4, REPEAT_DELAY=10, REPEAT_PERIOD=3)
REQ-029 Clean press: btn_i[0] 0->1 held -> level_o[0], press_o[0], step_o[0] rise on edge 6; press_o[0] high exactly one cycle.
REQ-030 Bounce: btn_i[1] toggling with 3-cycle high/low segments for 40 cycles -> level_o, press_o, release_o, step_o all stay 0.
REQ-031 Hold: press at cycle P, held 30 cycles -> step_o[0] at P, P+10, P+13, P+16, ...; press_o only at P.
REQ-032 Release: btn_i[0] falls during REPEAT -> release_o[0] pulse on edge 6 after fall, level_o[0]=0, no step_o thereafter.
REQ-033 Simultaneous: both btn_i bits rise in same cycle -> press_o=2'b11 in one cycle, then both return to 0.
REQ-034 Reset mid-hold: arstn_i low during REPEAT -> all outputs 0 immediately; btn still held -> press_o on edge 6 after deassertion, no release_o.
